// File: rtl/delivery_game_pkg.sv
// delivery_game_pkg: shared state codes and default timing constants for the delivery game control unit
package delivery_game_pkg;
  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    MEDE          = 4'd2,
    ESPERA_MEDIDA = 4'd3,
    JOGANDO       = 4'd4,
    FIM_JOGO      = 4'd5,
    PAUSA         = 4'd6
  } state_t;
  localparam int MEAS_PERIOD_DEF = 50_000_000;
  localparam int TIMEOUT_DEF     = 2_500_000;
endpackage

// File: rtl/edge_detector.sv
// edge_detector: one-cycle pulse on the rising edge of a raw level input
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic prev_q;
  // remember last sampled level; reset forgets it
  always_ff @(posedge clk) prev_q <= rst ? 1'b0 : d_i;
  assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/delivery_game_uc.sv
// delivery_game_uc: game control unit (start, periodic velocity measurement, game over); pause via DELIVERY_UC_PAUSE_EN
module delivery_game_uc
  import delivery_game_pkg::*;
#(
  parameter int MEAS_PERIOD = MEAS_PERIOD_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       game_over,
  input  logic       velocity_ready,
`ifdef DELIVERY_UC_PAUSE_EN
  input  logic       pausar,
`endif
  output logic       zera_fd,
  output logic       count_map,
  output logic       get_velocity,
  output logic       playing,
  output logic       timeout_err,
  output logic [3:0] db_estado
);
  localparam int PW = $clog2(MEAS_PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PER_LAST = PW'(MEAS_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] to_q, to_d;
  logic err_d, ini_rise, pau_rise;
  edge_detector u_ini (.clk(clock), .rst(reset), .d_i(iniciar), .rise_o(ini_rise));
`ifdef DELIVERY_UC_PAUSE_EN
  edge_detector u_pau (.clk(clock), .rst(reset), .d_i(pausar), .rise_o(pau_rise));
`else
  assign pau_rise = 1'b0;
`endif
  // next state and timers; game_over outranks every other exit from the active states
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    to_d    = to_q;
    err_d   = timeout_err;
    case (state_q)
      INICIAL, FIM_JOGO: if (ini_rise) begin
        state_d = PREPARA;
        err_d   = 1'b0;
      end
      PREPARA: state_d = MEDE;
      MEDE: begin
        state_d = game_over ? FIM_JOGO : ESPERA_MEDIDA;
        to_d    = '0;
      end
      ESPERA_MEDIDA: begin
        to_d = to_q + 1'b1;
        if (game_over) state_d = FIM_JOGO;
        else if (velocity_ready || to_q == TO_LAST) begin
          state_d = JOGANDO;
          per_d   = '0;
          err_d   = timeout_err | ~velocity_ready;
        end
      end
      JOGANDO:
        if (game_over) state_d = FIM_JOGO;
        else if (pau_rise) state_d = PAUSA;
        else if (per_q == PER_LAST) begin
          state_d = MEDE;
          per_d   = '0;
        end
        else per_d = per_q + 1'b1;
      PAUSA: state_d = game_over ? FIM_JOGO : pau_rise ? JOGANDO : PAUSA;
      default: state_d = INICIAL;
    endcase
  end
  // state, timers and Moore outputs decoded from the next state so they align with db_estado
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= INICIAL;
      per_q        <= '0;
      to_q         <= '0;
      zera_fd      <= 1'b0;
      count_map    <= 1'b0;
      get_velocity <= 1'b0;
      playing      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      to_q         <= to_d;
      zera_fd      <= state_d == PREPARA;
      count_map    <= state_d == ESPERA_MEDIDA || state_d == JOGANDO;
      get_velocity <= state_d == MEDE;
      playing      <= state_d == ESPERA_MEDIDA || state_d == JOGANDO || state_d == PAUSA;
      timeout_err  <= err_d;
    end
  end
  assign db_estado = state_q;
endmodule
